// File: rtl/polynomial_collector.sv
// Collects N coefficients from the upstream adder into a buffer. The buffer is
// then frozen for random-access reads until the consumer releases it.
module polynomial_collector #(
  parameter int q    = 17,
  parameter int N    = 8,
  parameter int logq = 5,
  parameter int logN = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid_i,
  input  logic [logq-1:0] in_data_i,
  output logic            in_ready_o,
  output logic            full_o,
  output logic [logN:0]   count_o,
  input  logic [logN-1:0] rd_addr_i,
  output logic [logq-1:0] rd_data_o,
  input  logic            release_i,
  output logic            range_err_o
);

  typedef enum logic {COLLECT, FULL} state_e;

  localparam logic [logq:0] QLimit    = (logq+1)'(q);
  localparam logic [logN:0] LastCount = (logN+1)'(N-1);

  state_e          state_q, state_d;
  logic [logN:0]   count_q, count_d;
  logic [logN-1:0] wr_ptr_q, wr_ptr_d;
  logic            range_err_q, range_err_d;
  logic            accept;
  logic [logq-1:0] buf_q [N];

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    range_err_d = range_err_q;
    in_ready_o  = (state_q == COLLECT);
    full_o      = (state_q == FULL);
    accept      = 1'b0;
    case (state_q)
      COLLECT: begin
        if (in_valid_i) begin
          accept   = 1'b1;
          count_d  = count_q + (logN+1)'(1);
          // wr_ptr is logN bits wide, so it wraps to 0 on the Nth accept
          wr_ptr_d = wr_ptr_q + logN'(1);
          if ({1'b0, in_data_i} >= QLimit) range_err_d = 1'b1;
          if (count_q == LastCount) state_d = FULL;
        end
      end
      FULL: begin
        if (release_i) begin
          state_d  = COLLECT;
          count_d  = '0;
          wr_ptr_d = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      range_err_q <= range_err_d;
    end
  end

  // Release only rewinds the pointer; stale entries survive until rewritten
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else if (accept) begin
      buf_q[wr_ptr_q] <= in_data_i;
    end
  end

  assign count_o     = count_q;
  assign range_err_o = range_err_q;
  assign rd_data_o   = buf_q[rd_addr_i];

endmodule

// File: tb/tb_polynomial_collector.sv
// Self-checking bench for polynomial_collector: directed scenarios plus a
// randomized phase, all compared against a behavioural buffer model.
module tb_polynomial_collector;

  localparam int Q = 17;
  localparam int NN = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       inValid;
  logic [4:0] inData;
  logic       inReady;
  logic       full;
  logic [3:0] count;
  logic [2:0] rdAddr;
  logic [4:0] rdData;
  logic       releaseReq;
  logic       rangeErr;

  int assertCount = 0;
  int failCount = 0;

  int modelMem [NN];
  int modelHeld;
  bit modelFull;
  bit modelRangeErr;

  polynomial_collector #(.q(Q), .N(NN), .logq(5), .logN(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(inValid), .in_data_i(inData), .in_ready_o(inReady),
    .full_o(full), .count_o(count),
    .rd_addr_i(rdAddr), .rd_data_o(rdData),
    .release_i(releaseReq), .range_err_o(rangeErr)
  );

  always #10 clk = ~clk;

  task automatic checkVal(input string tag, input int observed, input int expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NN; i++) modelMem[i] = 0;
    modelHeld = 0;
    modelFull = 0;
    modelRangeErr = 0;
  endtask

  // One rising edge of the reference: the buffer fills in order, then freezes
  task automatic modelStep(input bit v, input int d, input bit r);
    if (!modelFull) begin
      if (v) begin
        modelMem[modelHeld] = d;
        modelHeld++;
        if (d >= Q) modelRangeErr = 1;
        if (modelHeld == NN) modelFull = 1;
      end
    end else if (r) begin
      modelFull = 0;
      modelHeld = 0;
    end
  endtask

  task automatic checkOutput(input string tag);
    int a;
    checkVal({tag, ".full"}, int'(full), int'(modelFull));
    checkVal({tag, ".in_ready"}, int'(inReady), int'(!modelFull));
    checkVal({tag, ".count"}, int'(count), modelHeld);
    checkVal({tag, ".range_err"}, int'(rangeErr), int'(modelRangeErr));
    a = $urandom_range(NN-1, 0);
    rdAddr = 3'(a);
    #1;
    checkVal({tag, ".rd_data"}, int'(rdData), modelMem[a]);
  endtask

  task automatic checkAllEntries(input string tag);
    for (int i = 0; i < NN; i++) begin
      rdAddr = 3'(i);
      #1;
      checkVal($sformatf("%s.rd[%0d]", tag, i), int'(rdData), modelMem[i]);
    end
  endtask

  task automatic applyStimulus(input bit v, input int d, input bit r, input string tag);
    inValid = v;
    inData = 5'(d);
    releaseReq = r;
    @(posedge clk);
    modelStep(v, d, r);
    #1;
    inValid = 1'b0;
    releaseReq = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    inValid = 0; inData = 0; releaseReq = 0; rdAddr = 0;
    reset = 1'b1;
    modelReset();
    #3;
    checkOutput("reset");
    checkAllEntries("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("postreset");

    // Fill with 1..8 back to back
    for (int k = 1; k <= NN; k++) applyStimulus(1, k, 0, $sformatf("fill%0d", k));
    checkAllEntries("filled");

    // Frozen while full, even with in_valid held high
    for (int k = 0; k < 4; k++) applyStimulus(1, 5, 0, "frozen");
    rdAddr = 3'd3; #1;
    checkVal("frozen.rd3", int'(rdData), 4);

    // Release together with in_valid: no transfer that cycle
    applyStimulus(1, 5, 1, "release");
    applyStimulus(1, 9, 0, "accept9");
    rdAddr = 3'd0; #1;
    checkVal("accept9.rd0", int'(rdData), 9);
    rdAddr = 3'd1; #1;
    checkVal("accept9.rd1", int'(rdData), 2);

    // Release in COLLECT is ignored
    applyStimulus(1, 11, 0, "acc2");
    applyStimulus(1, 12, 0, "acc3");
    applyStimulus(0, 0, 1, "relCollect");
    checkVal("relCollect.count3", int'(count), 3);

    // Out-of-range coefficient is stored and flagged stickily
    applyStimulus(1, 20, 0, "range");
    checkVal("range.flag", int'(rangeErr), 1);
    rdAddr = 3'd3; #1;
    checkVal("range.stored", int'(rdData), 20);
    for (int k = 0; k < 4; k++) applyStimulus(1, k, 0, "toFull");
    applyStimulus(0, 0, 1, "rangeRelease");
    checkVal("range.sticky", int'(rangeErr), 1);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      applyStimulus(bit'($urandom_range(3, 0) != 0), int'($urandom_range(18, 0)),
                    bit'($urandom_range(3, 0) == 0), "random");
    end
    checkAllEntries("random");

    // Drain into a clean start, then async reset after 5 accepts
    applyStimulus(0, 0, 1, "drain");
    for (int k = 0; k < 8; k++) if (modelFull) applyStimulus(0, 0, 1, "drain");
    if (!modelFull && modelHeld != 0) begin
      while (!modelFull) applyStimulus(1, 3, 0, "drainFill");
      applyStimulus(0, 0, 1, "drainRel");
    end
    for (int k = 0; k < 5; k++) applyStimulus(1, 20 + k, 0, "pre");
    checkVal("pre.range", int'(rangeErr), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("asyncReset");
    checkAllEntries("asyncReset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("resetHold");
    for (int k = 1; k <= NN; k++) begin
      applyStimulus(1, 16 - k, 0, $sformatf("refill%0d", k));
      checkVal("refill.full", int'(full), int'(k == NN));
    end
    checkAllEntries("refill");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/polynomial_collector.md
POLYNOMIAL_COLLECTOR -- requirements
Module: polynomial_collector

Interface
REQ-001 Parameter q, default 17: coefficient modulus; accepted coefficients are expected in 0..q-1.
REQ-002 Parameter N, default 8: coefficients per polynomial; a power of two, at least 2.
REQ-003 Parameter logq, default 5: coefficient width in bits.
REQ-004 Parameter logN, default 3: log2(N).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  upstream stage presents a coefficient.
REQ-008 in_data  input  logq  coefficient from the upstream adder stage.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 full  output  1  all N coefficients held; buffer readable and frozen.
REQ-011 count  output  logN+1  number of coefficients currently held, 0..N.
REQ-012 rd_addr  input  logN  read index into the buffer.
REQ-013 rd_data  output  logq  buffer entry at rd_addr.
REQ-014 release  input  1  consumer has finished reading; frees the buffer.
REQ-015 range_err  output  1  sticky flag: a coefficient of value q or more was accepted.

Function
REQ-016 The block SHALL implement a two-state FSM, COLLECT and FULL; full SHALL be 1 exactly when the state is FULL.
REQ-017 in_ready SHALL be 1 in COLLECT and 0 in FULL, and SHALL depend on state only, never on in_valid.
REQ-018 A transfer occurs when in_valid and in_ready are both 1 on a rising edge; in_data SHALL then be written to buffer[wr_ptr], and wr_ptr and count SHALL each increment by 1.
REQ-019 On the transfer that makes count equal to N, the state SHALL become FULL on that same edge; wr_ptr SHALL wrap to 0.
REQ-020 In FULL, no write SHALL occur, and count and the buffer SHALL hold, whatever in_valid does.
REQ-021 rd_data SHALL equal buffer[rd_addr] combinationally, with zero latency, in either state.
REQ-022 release sampled 1 in FULL SHALL move the state to COLLECT on that edge, and SHALL set count and wr_ptr to 0; the buffer contents SHALL be kept.
REQ-023 release sampled in COLLECT SHALL be ignored.
REQ-024 release and in_valid both 1 in FULL: no transfer that cycle; in_ready becomes 1 in the following cycle.
REQ-025 Entries not yet overwritten after a release SHALL keep their previous values until they are rewritten.
REQ-026 Accepting in_data >= q SHALL set range_err to 1; the value SHALL still be stored unchanged; range_err SHALL clear only on reset.
REQ-027 Throughput in COLLECT SHALL be one coefficient per cycle; minimum gap from the last accept to the first accept of the next polynomial is 2 cycles (FULL for one cycle, then release).

Reset
REQ-028 Asserting reset SHALL immediately (asynchronously) force: state COLLECT, full 0, in_ready 1, count 0, wr_ptr 0, range_err 0, all buffer entries 0.
REQ-029 Reset asserted mid-collection SHALL discard the partial polynomial; after deassertion, the next accepted coefficient SHALL go to index 0.
REQ-030 Outputs SHALL keep their reset values until the first rising edge after reset deasserts.

Verification
REQ-031 Continuous in_valid with data 1..8 (q=17, N=8) -> count rises 1..8 on consecutive edges; full=1 after the 8th edge; rd_addr 0..7 reads 1..8; in_ready=0.
REQ-032 In FULL, hold in_valid=1 with data 5 for 4 cycles -> count stays 8, rd_addr=3 reads 4, no write occurs.
REQ-033 Pulse release in FULL -> the next cycle shows full=0, count=0, in_ready=1; the next accepted value 9 lands at index 0, while rd_addr=1 still reads 2.
REQ-034 Pulse release in COLLECT with count=3 -> count stays 3; the state is unchanged.
REQ-035 Accept in_data=20 (>= 17) -> range_err=1 and stays 1 through a release; reset clears it to 0.
REQ-036 Assert reset after 5 accepts -> immediately count=0, full=0, in_ready=1, rd_data=0 for every address; after deassertion, 8 accepts are needed to reach full.
